// File: rtl/yd_regfile_mp_pkg.sv
// Shared constants for the yd_regfile_mp register file: reserved addresses and PC location.
package yd_pkg;

    localparam int unsigned ADDR_ZERO = 0;
    localparam int unsigned ADDR_DK   = 1;
    localparam int unsigned ADDR_R0   = 2;

    // PC always lives at the top of the address space
    function automatic int unsigned addr_pc(input int unsigned aw);
        return (32'd1 << aw) - 32'd1;
    endfunction

endpackage

// File: rtl/yd_wr_arbiter.sv
// Write-port arbitration: lowest-index enabled port wins each address,
// and any shared non-ZERO target raises a conflict.
module yd_wr_arbiter
    import yd_pkg::*;
#(
    parameter int AW  = 4,
    parameter int NWR = 2
) (
    input  logic [NWR-1:0]    we,
    input  logic [NWR*AW-1:0] waddr,
    output logic [NWR-1:0]    win,
    output logic              conflict
);

    localparam logic [AW-1:0] A_ZERO = AW'(ADDR_ZERO);

    always_comb begin
        win      = '0;
        conflict = 1'b0;
        for (int k = 0; k < NWR; k++) begin
            win[k] = we[k];
            for (int j = 0; j < k; j++) begin
                if (we[j] && we[k] &&
                    (waddr[j*AW +: AW] == waddr[k*AW +: AW])) begin
                    win[k] = 1'b0;
                    if (waddr[k*AW +: AW] != A_ZERO) begin
                        conflict = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/yd_regfile_mp.sv
// Parametrised multi-port register file with registered reads and PC.
// Define YD_REGFILE_BYPASS_EN for write-through reads; default is read-before-write.
module yd_regfile_mp
    import yd_pkg::*;
#(
    parameter int DW      = 16,
    parameter int AW      = 4,
    parameter int NRD     = 2,
    parameter int NWR     = 2,
    parameter int PC_STEP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jpc,
    input  logic [NWR-1:0]    we,
    input  logic [NWR*AW-1:0] waddr,
    input  logic [NWR*DW-1:0] wdata,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD*DW-1:0] rdata,
    output logic [DW-1:0]     pc_o,
    output logic              wr_conflict
);

    localparam int NREG = 2 ** AW;
    localparam logic [AW-1:0] A_ZERO = AW'(ADDR_ZERO);
    localparam logic [AW-1:0] A_PC   = AW'(addr_pc(AW));

    logic [DW-1:0]  regs_q [NREG];
    logic [DW-1:0]  regs_d [NREG];
    logic           conflict_q;
    logic           conflict_d;
    logic [NWR-1:0] win;
    logic [NWR-1:0] wr_ok;
    logic           arb_conflict;

    yd_wr_arbiter #(
        .AW  (AW),
        .NWR (NWR)
    ) u_arb (
        .we       (we),
        .waddr    (waddr),
        .win      (win),
        .conflict (arb_conflict)
    );

    // A winning write only lands if it avoids ZERO, and PC only when frozen
    always_comb begin
        wr_ok = '0;
        for (int k = 0; k < NWR; k++) begin
            wr_ok[k] = win[k]
                && (waddr[k*AW +: AW] != A_ZERO)
                && ((waddr[k*AW +: AW] != A_PC) || jpc);
        end
    end

    always_comb begin
        regs_d = regs_q;
        for (int k = 0; k < NWR; k++) begin
            if (wr_ok[k]) begin
                regs_d[waddr[k*AW +: AW]] = wdata[k*DW +: DW];
            end
        end
        regs_d[A_ZERO] = '0;
        if (!jpc) begin
            regs_d[A_PC] = regs_q[A_PC] + DW'(PC_STEP);
        end
        conflict_d = conflict_q | arb_conflict;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            conflict_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            conflict_q <= conflict_d;
        end
    end

    for (genvar r = 0; r < NRD; r++) begin : g_rd
        logic [AW-1:0] ra;
        logic [DW-1:0] rd_d;
        logic [DW-1:0] rd_q;

        assign ra = raddr[r*AW +: AW];

        always_comb begin
            rd_d = regs_q[ra];
`ifdef YD_REGFILE_BYPASS_EN
            for (int k = NWR - 1; k >= 0; k--) begin
                if (wr_ok[k] && (waddr[k*AW +: AW] == ra)) begin
                    rd_d = wdata[k*DW +: DW];
                end
            end
`endif
            if (ra == A_ZERO) begin
                rd_d = '0;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_q <= '0;
            end else begin
                rd_q <= rd_d;
            end
        end

        assign rdata[r*DW +: DW] = rd_q;
    end

    assign pc_o        = regs_q[A_PC];
    assign wr_conflict = conflict_q;

endmodule

// File: tb/tb_yd_regfile_mp.sv
// Directed table-driven bench for yd_regfile_mp (default and 32-bit/3R/1W builds).
module tb_yd_regfile_mp;

`ifdef YD_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        jpc;
    logic [1:0]  we;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic [7:0]  raddr;
    logic [31:0] rdata;
    logic [15:0] pc_o;
    logic        wr_conflict;

    logic        rst2;
    logic        jpc2;
    logic [0:0]  we2;
    logic [4:0]  waddr2;
    logic [31:0] wdata2;
    logic [14:0] raddr2;
    logic [95:0] rdata2;
    logic [31:0] pc2;
    logic        conf2;

    int checks = 0;
    int errors = 0;

    yd_regfile_mp dut (
        .clk         (clk),
        .rst         (rst),
        .jpc         (jpc),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .raddr       (raddr),
        .rdata       (rdata),
        .pc_o        (pc_o),
        .wr_conflict (wr_conflict)
    );

    yd_regfile_mp #(
        .DW  (32),
        .AW  (5),
        .NRD (3),
        .NWR (1)
    ) dut2 (
        .clk         (clk),
        .rst         (rst2),
        .jpc         (jpc2),
        .we          (we2),
        .waddr       (waddr2),
        .wdata       (wdata2),
        .raddr       (raddr2),
        .rdata       (rdata2),
        .pc_o        (pc2),
        .wr_conflict (conf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        jpc;
        logic [1:0]  we;
        logic [3:0]  wa0, wa1;
        logic [15:0] wd0, wd1;
        logic [3:0]  ra0, ra1;
        logic [15:0] nb0, nb1;
        logic [15:0] b0, b1;
        logic [15:0] pc;
        logic        conf;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vecs = '{
            '{0, 0, 0, 0, 0, 0, 15, 0, 0, 0, 0, 0, 1, 0},
            '{0, 0, 0, 0, 0, 0, 15, 15, 1, 1, 1, 1, 2, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0},
            '{0, 3, 3, 4, 16'h1234, 16'hBEEF, 3, 4,
              0, 0, 16'h1234, 16'hBEEF, 4, 0},
            '{0, 0, 0, 0, 0, 0, 3, 4,
              16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF, 5, 0},
            '{0, 3, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0, 0, 0, 6, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0},
            '{0, 3, 5, 5, 16'hAAAA, 16'h5555, 5, 1,
              0, 0, 16'hAAAA, 0, 8, 1},
            '{0, 0, 0, 0, 0, 0, 5, 5,
              16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 9, 1},
            '{0, 3, 1, 2, 16'h1111, 16'h2222, 1, 2,
              0, 0, 16'h1111, 16'h2222, 10, 1},
            '{0, 0, 0, 0, 0, 0, 1, 2,
              16'h1111, 16'h2222, 16'h1111, 16'h2222, 11, 1},
            '{0, 1, 15, 0, 16'h0100, 0, 15, 0, 11, 0, 11, 0, 12, 1},
            '{1, 1, 15, 0, 16'h0100, 0, 15, 0,
              12, 0, 16'h0100, 0, 16'h0100, 1},
            '{1, 0, 0, 0, 0, 0, 15, 15,
              16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 1},
            '{1, 0, 0, 0, 0, 0, 15, 15,
              16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 1},
            '{1, 3, 15, 15, 16'h0200, 16'h0300, 15, 0,
              16'h0100, 0, 16'h0200, 0, 16'h0200, 1},
            '{0, 0, 0, 0, 0, 0, 15, 0,
              16'h0200, 0, 16'h0200, 0, 16'h0201, 1},
            '{0, 0, 0, 0, 0, 0, 5, 3,
              16'hAAAA, 16'h1234, 16'hAAAA, 16'h1234, 16'h0202, 1}
        };

        rst    = 1'b1;
        jpc    = 1'b0;
        we     = '0;
        waddr  = '0;
        wdata  = '0;
        raddr  = '0;
        rst2   = 1'b1;
        jpc2   = 1'b0;
        we2    = '0;
        waddr2 = '0;
        wdata2 = '0;
        raddr2 = '0;

        #3;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_pc", {16'h0, pc_o}, 32'h0);
        chk("reset_conflict", {31'h0, wr_conflict}, 32'h0);

        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            jpc   = vecs[i].jpc;
            we    = vecs[i].we;
            waddr = {vecs[i].wa1, vecs[i].wa0};
            wdata = {vecs[i].wd1, vecs[i].wd0};
            raddr = {vecs[i].ra1, vecs[i].ra0};
            step();
            chk($sformatf("row%0d_rdata0", i), {16'h0, rdata[15:0]},
                {16'h0, BYP ? vecs[i].b0 : vecs[i].nb0});
            chk($sformatf("row%0d_rdata1", i), {16'h0, rdata[31:16]},
                {16'h0, BYP ? vecs[i].b1 : vecs[i].nb1});
            chk($sformatf("row%0d_pc", i), {16'h0, pc_o},
                {16'h0, vecs[i].pc});
            chk($sformatf("row%0d_conflict", i), {31'h0, wr_conflict},
                {31'h0, vecs[i].conf});
        end

        // Mid-cycle reset with writes pending to 6 and 7
        jpc   = 1'b0;
        we    = 2'b11;
        waddr = {4'd7, 4'd6};
        wdata = {16'h7777, 16'h6666};
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_rdata", rdata, 32'h0);
        chk("midrst_pc", {16'h0, pc_o}, 32'h0);
        chk("midrst_conflict", {31'h0, wr_conflict}, 32'h0);
        step();
        rst   = 1'b0;
        we    = '0;
        raddr = {4'd5, 4'd6};
        step();
        chk("postrst_reg6", {16'h0, rdata[15:0]}, 32'h0);
        chk("postrst_reg5", {16'h0, rdata[31:16]}, 32'h0);
        chk("postrst_pc", {16'h0, pc_o}, 32'h1);
        raddr = {4'd0, 4'd7};
        step();
        chk("postrst_reg7", {16'h0, rdata[15:0]}, 32'h0);
        chk("postrst_pc2", {16'h0, pc_o}, 32'h2);

        // Wide configuration: PC at address 31, three read ports
        chk("p2_reset_pc", pc2, 32'h0);
        chk("p2_reset_rdata0", rdata2[31:0], 32'h0);
        rst2   = 1'b0;
        jpc2   = 1'b1;
        we2    = 1'b1;
        waddr2 = 5'd31;
        wdata2 = 32'hFFFF_FFFE;
        raddr2 = {5'd31, 5'd31, 5'd31};
        step();
        chk("p2_load_pc", pc2, 32'hFFFF_FFFE);
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("p2_load_rd%0d", p), rdata2[p*32 +: 32],
                BYP ? 32'hFFFF_FFFE : 32'h0);
        end
        jpc2 = 1'b0;
        we2  = 1'b0;
        step();
        chk("p2_inc_pc", pc2, 32'hFFFF_FFFF);
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("p2_inc_rd%0d", p), rdata2[p*32 +: 32],
                32'hFFFF_FFFE);
        end
        step();
        chk("p2_wrap_pc", pc2, 32'h0);
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("p2_wrap_rd%0d", p), rdata2[p*32 +: 32],
                32'hFFFF_FFFF);
        end
        step();
        chk("p2_after_wrap_pc", pc2, 32'h1);
        chk("p2_after_wrap_rd0", rdata2[31:0], 32'h0);
        chk("p2_conflict", {31'h0, conf2}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/yd_regfile_mp.md
Name: yd_regfile_mp

Overview:
- Parametrised multi-port register file; successor to the fixed 16-bit, 2R/2W Yduck register file.
- Same reserved-address map: ZERO, DK, general registers, PC.
- Configurable data width, address width, and number of read and write ports.
- Adds registered read data with optional write-through bypass, PC step and PC output, and a sticky write-conflict flag. Sits between decode and execute stages.

Parameters:
- DW, 16, data width of every register.
- AW, 4, register address width; register count = 2**AW, AW >= 2.
- NRD, 2, number of read ports, >= 1.
- NWR, 2, number of write ports, >= 1.
- PC_STEP, 1, PC increment applied per non-jump cycle.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- jpc  in  1  jump/bubble; 1 = PC frozen except explicit write, 0 = PC += PC_STEP
- we  in  NWR  write enable, one bit per write port
- waddr  in  NWR*AW  write addresses, port k at bits [k*AW +: AW]
- wdata  in  NWR*DW  write data, port k at bits [k*DW +: DW]
- raddr  in  NRD*AW  read addresses
- rdata  out  NRD*DW  registered read data
- pc_o  out  DW  current PC register
- wr_conflict  out  1  sticky: two enabled write ports hit the same non-ZERO address

Behaviour:
- Address map:
  - 0 = ZERO: reads 0, writes ignored.
  - 1 = DK.
  - 2 .. 2**AW-2 = general registers.
  - 2**AW-1 = PC.
- Reset (async assert, sync release): all registers, rdata, and wr_conflict go to 0; pc_o = 0.
- Writes commit on the rising edge of clk when we[k]=1.
- Same-address conflict: the lowest-index enabled port wins; all other ports to that address are dropped that cycle.
- Ports writing distinct addresses all commit in the same cycle.
- PC:
  - jpc=0: PC <= PC + PC_STEP, modulo 2**DW; any write to the PC address is ignored.
  - jpc=1: PC holds, unless a write port targets PC, in which case the winning port's data loads.
- Read latency: exactly 1 cycle.
  - raddr presented in cycle N; rdata valid from the edge ending cycle N through cycle N+1.
  - rdata is taken from array contents before that edge's writes.
- Same-cycle read/write hazard: a read in cycle N of an address written in cycle N follows the Optional Feature.
- Read address ZERO always returns 0, regardless of bypass.
- Read of PC with no bypassing write returns the pre-increment PC of cycle N.
- wr_conflict sets on the edge after any cycle in which ≥2 enabled ports share a non-ZERO address. It clears only on rst.
- Reset asserted mid-operation: pending writes are discarded and rdata returns to 0 immediately.

Optional Feature:
- Macro YD_REGFILE_BYPASS_EN.
- Defined: write-through. A read in cycle N that matches an enabled write in cycle N returns that write's data in cycle N+1.
  - With several matching ports, the lowest-index port wins.
  - A PC write only bypasses when jpc=1.
  - ZERO is never bypassed.
- Undefined: read-before-write. Returns the old value; no bypass logic is generated.

Decomposition:
- Package yd_pkg: address constants ADDR_ZERO=0, ADDR_DK=1, ADDR_R0=2, and function addr_pc(AW).
- Sub-module yd_wr_arbiter: per-address winning-port select plus conflict detect; instantiated once.
- Read path: one generate loop per read port.

Test Plan:
- Reset: assert rst mid-cycle → rdata=0, pc_o=0, wr_conflict=0 without waiting for a clock edge; release, 3 clocks with jpc=0 → pc_o=3.
- Port priority: we=2'b11, waddr both 5, wdata0=16'hAAAA, wdata1=16'h5555 → reg5=16'hAAAA, wr_conflict=1 next cycle and stays 1.
- Bypass: write reg3=16'h1234 and read raddr0=3 in the same cycle → rdata0=16'h1234 with macro, previous value without.
- ZERO register: write 16'hFFFF to address 0, then read address 0 → rdata=0; wr_conflict not set even with both ports hitting 0.
- PC gating:
  - jpc=0, write PC=16'h0100 → ignored, PC increments.
  - jpc=1, same write → pc_o=16'h0100, then holds while jpc=1.
- Parametrised config: DW=32, AW=5, NRD=3, NWR=1; read PC (addr 31) on all 3 ports → identical values; PC wraps from 32'hFFFFFFFF to 0.
